// File: rtl/vtg_pkg.sv
// Shared timing constants, derived totals and pipeline bundle for video_timing_gen.
// VTG_TEST_PATTERN_EN adds the colour-bar fields to the stage bundle.
package vtg_pkg;

  localparam int unsigned CW = 11;
  localparam int unsigned PIPE_DEPTH = 3;

  localparam int unsigned SVGA_HAPIX = 800;
  localparam int unsigned SVGA_HFPOR = 40;
  localparam int unsigned SVGA_HSPUL = 128;
  localparam int unsigned SVGA_HBPOR = 88;
  localparam int unsigned SVGA_VAPIX = 600;
  localparam int unsigned SVGA_VFPOR = 1;
  localparam int unsigned SVGA_VSPUL = 4;
  localparam int unsigned SVGA_VBPOR = 23;

  localparam int unsigned XGA_HAPIX = 1024;
  localparam int unsigned XGA_HFPOR = 24;
  localparam int unsigned XGA_HSPUL = 136;
  localparam int unsigned XGA_HBPOR = 160;
  localparam int unsigned XGA_VAPIX = 768;
  localparam int unsigned XGA_VFPOR = 3;
  localparam int unsigned XGA_VSPUL = 6;
  localparam int unsigned XGA_VBPOR = 29;

  typedef logic [7:0] chan_t;

  typedef struct packed {
    logic act;
    logic req;
    logic hs;
    logic vs;
    logic fs;
`ifdef VTG_TEST_PATTERN_EN
    logic pat;
    logic [2:0] bar;
`endif
  } vtg_ctl_t;

  function automatic int unsigned htotal(
    input int unsigned a, input int unsigned f,
    input int unsigned s, input int unsigned b);
    return a + f + s + b;
  endfunction

  function automatic int unsigned vtotal(
    input int unsigned a, input int unsigned f,
    input int unsigned s, input int unsigned b);
    return a + f + s + b;
  endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Pixel fetch handshake towards the frame source and raster/RGB towards the encoder.
interface video_timing_gen_if;
  import vtg_pkg::*;

  logic  oPixReq;
  logic  iPixValid;
  chan_t iRed;
  chan_t iGreen;
  chan_t iBlue;
  chan_t oRed;
  chan_t oGreen;
  chan_t oBlue;
  logic  SYNC_H;
  logic  SYNC_V;
  logic  DE;
  logic  oFrameStart;
  logic  oUnderflow;

  modport master (
    output oPixReq,
    input  iPixValid, iRed, iGreen, iBlue,
    output oRed, oGreen, oBlue,
    output SYNC_H, SYNC_V, DE,
    output oFrameStart, oUnderflow
  );

  modport slave (
    input  oPixReq,
    output iPixValid, iRed, iGreen, iBlue,
    input  oRed, oGreen, oBlue,
    input  SYNC_H, SYNC_V, DE,
    input  oFrameStart, oUnderflow
  );

endinterface

// File: rtl/vtg_axis_counter.sv
// One raster axis: counts 0..LEN-1 while enabled, pulses wrap on the last count.
module vtg_axis_counter
  import vtg_pkg::*;
#(
  parameter int unsigned LEN = 1056
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          clr,
  output logic [CW-1:0] cnt,
  output logic          wrap
);

  localparam logic [CW-1:0] LAST = CW'(LEN - 1);

  assign wrap = en && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= wrap ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing + pixel fetch pipeline (S0 count, S1 request, S2 return, S3 output).
// VTG_TEST_PATTERN_EN adds iPatSel and an 8-bar colour pattern.
module video_timing_gen
  import vtg_pkg::*;
#(
  parameter int unsigned HAPIX = SVGA_HAPIX,
  parameter int unsigned HFPOR = SVGA_HFPOR,
  parameter int unsigned HSPUL = SVGA_HSPUL,
  parameter int unsigned HBPOR = SVGA_HBPOR,
  parameter int unsigned VAPIX = SVGA_VAPIX,
  parameter int unsigned VFPOR = SVGA_VFPOR,
  parameter int unsigned VSPUL = SVGA_VSPUL,
  parameter int unsigned VBPOR = SVGA_VBPOR
) (
  input  logic clock_pixel,
  input  logic reset_n,
  input  logic iEnable,
  input  logic iClrErr,
`ifdef VTG_TEST_PATTERN_EN
  input  logic iPatSel,
`endif
  video_timing_gen_if.master vif
);

  localparam int unsigned HTOTAL = htotal(HAPIX, HFPOR, HSPUL, HBPOR);
  localparam int unsigned VTOTAL = vtotal(VAPIX, VFPOR, VSPUL, VBPOR);

  localparam logic [CW-1:0] H_ACT = CW'(HAPIX);
  localparam logic [CW-1:0] HS_ON = CW'(HAPIX + HFPOR);
  localparam logic [CW-1:0] HS_OFF = CW'(HAPIX + HFPOR + HSPUL);
  localparam logic [CW-1:0] V_ACT = CW'(VAPIX);
  localparam logic [CW-1:0] VS_ON = CW'(VAPIX + VFPOR);
  localparam logic [CW-1:0] VS_OFF = CW'(VAPIX + VFPOR + VSPUL);

  logic [CW-1:0] cont_x;
  logic [CW-1:0] cont_y;
  logic h_wrap;
  logic v_wrap;
  logic sof;
  logic uf_set;
  logic [23:0] pix;
  vtg_ctl_t s0, s1, s2;

  vtg_axis_counter #(.LEN(HTOTAL)) u_hcnt (
    .clk  (clock_pixel),
    .rst_n(reset_n),
    .en   (iEnable),
    .clr  (!iEnable),
    .cnt  (cont_x),
    .wrap (h_wrap)
  );

  vtg_axis_counter #(.LEN(VTOTAL)) u_vcnt (
    .clk  (clock_pixel),
    .rst_n(reset_n),
    .en   (h_wrap),
    .clr  (!iEnable),
    .cnt  (cont_y),
    .wrap (v_wrap)
  );

  // Armed at frame end or while stopped; the next active pixel is (0,0).
  always_ff @(posedge clock_pixel or negedge reset_n) begin
    if (!reset_n) begin
      sof <= 1'b1;
    end else if (!iEnable || v_wrap) begin
      sof <= 1'b1;
    end else if (s0.act) begin
      sof <= 1'b0;
    end
  end

  always_comb begin
    s0 = '0;
    s0.act = iEnable && (cont_x < H_ACT) && (cont_y < V_ACT);
    s0.hs = iEnable && (cont_x >= HS_ON) && (cont_x < HS_OFF);
    s0.vs = iEnable && (cont_y >= VS_ON) && (cont_y < VS_OFF);
    s0.fs = s0.act && sof;
`ifdef VTG_TEST_PATTERN_EN
    s0.pat = iPatSel;
    s0.bar = cont_x[9:7];
    s0.req = s0.act && !iPatSel;
`else
    s0.req = s0.act;
`endif
  end

  always_ff @(posedge clock_pixel or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= s0;
      s2 <= s1;
    end
  end

  assign vif.oPixReq = s1.req;

  always_comb begin
    uf_set = s2.req && !vif.iPixValid;
    pix = '0;
    if (s2.req && vif.iPixValid) begin
      pix = {vif.iRed, vif.iGreen, vif.iBlue};
    end
`ifdef VTG_TEST_PATTERN_EN
    if (s2.pat && s2.act) begin
      pix = {{8{s2.bar[2]}}, {8{s2.bar[1]}}, {8{s2.bar[0]}}};
    end
`endif
  end

  always_ff @(posedge clock_pixel or negedge reset_n) begin
    if (!reset_n) begin
      vif.SYNC_H <= 1'b1;
      vif.SYNC_V <= 1'b1;
      vif.DE <= 1'b0;
      vif.oFrameStart <= 1'b0;
      vif.oUnderflow <= 1'b0;
      {vif.oRed, vif.oGreen, vif.oBlue} <= '0;
    end else begin
      vif.SYNC_H <= !s2.hs;
      vif.SYNC_V <= !s2.vs;
      vif.DE <= s2.act;
      vif.oFrameStart <= s2.fs;
      {vif.oRed, vif.oGreen, vif.oBlue} <= pix;
      if (uf_set) begin
        vif.oUnderflow <= 1'b1;
      end else if (iClrErr) begin
        vif.oUnderflow <= 1'b0;
      end
    end
  end

endmodule
